mips_multicycle_controller: RTL and testbench
=============================================

Name: mips_multicycle_controller

Overview:
Moore-style FSM that sequences the shared-memory multi-cycle MIPS datapath: one memory port for instructions and data, one ALU reused for PC increment, branch target and execute. It decodes opcode/funct from the instruction register and drives every datapath select, write-enable and ALU operation. Memory accesses use a ready handshake, so the controller inserts wait states. It halts on illegal instructions or memory timeout.

Parameters:
MAX_WAIT, 15, max consecutive cycles a state may wait for mem_ready before timeout halt (1..255)
CNT_W, 32, width of performance counters (optional feature only)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-low reset (0 = reset)
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes current read/write this cycle
pc_write  out  1  PC load enable
i_or_d  out  1  memory address: 0=PC, 1=ALUOut
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  instruction register load
reg_dest  out  1  write reg: 0=rt, 1=rd
mem_to_reg  out  1  write data: 0=ALUOut, 1=MDR
reg_write  out  1  register file write enable
jal  out  1  force write reg 31, write data = PC
alu_src_a  out  1  0=PC, 1=regA
alu_src_b  out  2  00=regB, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
alu_operation  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
pc_src  out  2  00=ALU result, 01=ALUOut, 10={PC[31:28],IR[25:0],00}, 11=regA
halted  out  1  sticky halt indication
halt_cause  out  2  00 none, 01 illegal instruction, 10 memory timeout

Behaviour:
- States: IDLE, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, R_WB, EXEC_I, I_WB, BRANCH, JUMP, JAL, JR, HALT.
- rst=0: state=IDLE, wait counter=0, halt_cause=00; every output 0. IDLE outputs all 0; IDLE->FETCH on first clock with rst=1.
- Unlisted outputs are 0 in each state. alu_operation=010 unless stated.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01. ir_write=pc_write=mem_ready (Mealy gating). Go to DECODE on mem_ready, else stay.
- DECODE: alu_src_a=0, alu_src_b=11 (branch target into ALUOut). Next state by opcode:
  - lw 100011 / sw 101011 -> MEM_ADDR
  - 000000 -> EXEC_R if funct in {100000,100010,100100,100101,101010}; JR if funct=001000; else HALT with cause 01
  - addi 001000 / slti 001010 -> EXEC_I
  - beq 000100 / bne 000101 -> BRANCH
  - j 000010 -> JUMP
  - jal 000011 -> JAL
  - any other opcode -> HALT with cause 01
- MEM_ADDR: alu_src_a=1, alu_src_b=10. Next is MEM_READ (lw) or MEM_WRITE (sw).
- MEM_READ: mem_read=1, i_or_d=1. Go to MEM_WB on mem_ready.
- MEM_WB: reg_write=1, reg_dest=0, mem_to_reg=1. Then FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1. Go to FETCH on mem_ready.
- EXEC_R: alu_src_a=1, alu_src_b=00. alu_operation from funct: add 010, sub 110, and 000, or 001, slt 111. Then R_WB.
- R_WB: reg_write=1, reg_dest=1, mem_to_reg=0, alu_operation held as in EXEC_R. Then FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_operation 010 (addi) or 111 (slti). Then I_WB.
- I_WB: reg_write=1, reg_dest=0, mem_to_reg=0, same alu_operation. Then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_operation=110, pc_src=01. pc_write=zero for beq, ~zero for bne. Then FETCH.
- JUMP: pc_src=10, pc_write=1. Then FETCH.
- JAL: pc_src=10, pc_write=1, reg_write=1, jal=1. PC already holds PC+4. Then FETCH.
- JR: pc_src=11, pc_write=1. Then FETCH.
- Opcode and funct are sampled only in DECODE and EXEC_R/R_WB; the IR is stable there.
- Latency without waits: lw 5, sw 4, R/addi/slti 4, beq/bne/j/jal/jr 3 cycles.
- Wait counter: increments each cycle in FETCH/MEM_READ/MEM_WRITE with mem_ready=0. It clears on any state change or on mem_ready=1. If it reaches MAX_WAIT with mem_ready still 0, go to HALT with cause 10; strobes drop next cycle.
- mem_ready in non-memory states is ignored.
- HALT: all outputs 0 except halted=1 and halt_cause; absorbing until rst=0.
- Reset asserted mid-instruction aborts immediately. No partial writes occur after rst falls.

Optional Feature:
PERF_COUNTERS_EN: adds outputs cycle_count[CNT_W-1:0] and instr_count[CNT_W-1:0], both reset to 0.
- cycle_count increments every cycle state is not IDLE/HALT.
- instr_count increments on each transition into FETCH from a completing state (not from IDLE).
- Both wrap at 2^CNT_W.
- Without the macro, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then release, mem_ready=1, opcode=100011 -> states IDLE,FETCH,DECODE,MEM_ADDR,MEM_READ,MEM_WB,FETCH; reg_write=1 with mem_to_reg=1 only in MEM_WB.
- opcode=000000, funct=101010, mem_ready=1 -> EXEC_R and R_WB drive alu_operation=111, reg_dest=1; reg_write=1 for exactly 1 cycle; 4 cycles total.
- beq with zero=1, then bne with zero=1 -> pc_write=1 with pc_src=01 in first BRANCH; pc_write=0 in second.
- jal -> JAL cycle has pc_write=1, reg_write=1, jal=1, pc_src=10; jr (funct 001000) -> pc_src=11, pc_write=1.
- FETCH with mem_ready held 0, MAX_WAIT=15 -> stays FETCH 15 cycles with ir_write=0; then HALT with halted=1, halt_cause=10 until rst=0.
- opcode=111111 -> DECODE->HALT, halt_cause=01. Assert rst=0 mid-sw MEM_WRITE wait -> outputs 0 immediately; restart from IDLE.

Source files
------------

// File: rtl/mips_multicycle_controller.sv
// ============================================================================
// Module   : mips_multicycle_controller
// Purpose  : Moore control FSM for a shared-memory multi-cycle MIPS datapath
//            with memory wait states and timeout / illegal-instruction halt.
//            Optional macro PERF_COUNTERS_EN adds cycle and instruction counters.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mips_multicycle_controller #(
  parameter int MAX_WAIT = 15
`ifdef PERF_COUNTERS_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dest,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       jal,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_operation,
  output logic [1:0] pc_src,
  output logic       halted,
  output logic [1:0] halt_cause
`ifdef PERF_COUNTERS_EN
  , output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
`endif
);

  localparam logic [3:0] S_IDLE      = 4'd0,  S_FETCH    = 4'd1,  S_DECODE  = 4'd2,
                         S_MEM_ADDR  = 4'd3,  S_MEM_READ = 4'd4,  S_MEM_WB  = 4'd5,
                         S_MEM_WRITE = 4'd6,  S_EXEC_R   = 4'd7,  S_R_WB    = 4'd8,
                         S_EXEC_I    = 4'd9,  S_I_WB     = 4'd10, S_BRANCH  = 4'd11,
                         S_JUMP      = 4'd12, S_JAL      = 4'd13, S_JR      = 4'd14,
                         S_HALT      = 4'd15;

  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW  = 6'b100011, OP_SW   = 6'b101011,
                         OP_ADDI  = 6'b001000, OP_SLTI = 6'b001010, OP_BEQ = 6'b000100,
                         OP_BNE   = 6'b000101, OP_J    = 6'b000010, OP_JAL = 6'b000011;
  localparam logic [5:0] FN_JR = 6'b001000;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01, CAUSE_TIMEOUT = 2'b10;
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  logic [3:0] state, next_state;
  logic [1:0] next_cause, cause_q;
  logic [7:0] wait_cnt;
  logic [5:0] op_q;
  logic       mem_state, timeout;

  function automatic logic r_legal(input logic [5:0] f);
    return (f == 6'b100000) || (f == 6'b100010) || (f == 6'b100100) ||
           (f == 6'b100101) || (f == 6'b101010);
  endfunction

  function automatic logic [2:0] r_alu_op(input logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  assign mem_state = (state == S_FETCH) || (state == S_MEM_READ) || (state == S_MEM_WRITE);
  assign timeout   = mem_state && !mem_ready && (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= next_state;
  end

  // Wait counter, halt cause and the opcode latched in DECODE for later states.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= 8'd0;
      cause_q  <= 2'b00;
      op_q     <= 6'd0;
    end else begin
      if (mem_state && !mem_ready && next_state == state) wait_cnt <= wait_cnt + 8'd1;
      else                                                 wait_cnt <= 8'd0;
      if (next_state == S_HALT && state != S_HALT) cause_q <= next_cause;
      if (state == S_DECODE) op_q <= opcode;
    end
  end

  always_comb begin
    next_state = state;
    next_cause = 2'b00;
    case (state)
      S_IDLE:      next_state = S_FETCH;
      S_FETCH:     if (mem_ready) next_state = S_DECODE;
                   else if (timeout) begin next_state = S_HALT; next_cause = CAUSE_TIMEOUT; end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:     next_state = S_MEM_ADDR;
          OP_ADDI, OP_SLTI: next_state = S_EXEC_I;
          OP_BEQ, OP_BNE:   next_state = S_BRANCH;
          OP_J:             next_state = S_JUMP;
          OP_JAL:           next_state = S_JAL;
          OP_RTYPE:
            if (r_legal(funct))    next_state = S_EXEC_R;
            else if (funct == FN_JR) next_state = S_JR;
            else begin next_state = S_HALT; next_cause = CAUSE_ILLEGAL; end
          default: begin next_state = S_HALT; next_cause = CAUSE_ILLEGAL; end
        endcase
      end
      S_MEM_ADDR:  next_state = (op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (mem_ready) next_state = S_MEM_WB;
                   else if (timeout) begin next_state = S_HALT; next_cause = CAUSE_TIMEOUT; end
      S_MEM_WRITE: if (mem_ready) next_state = S_FETCH;
                   else if (timeout) begin next_state = S_HALT; next_cause = CAUSE_TIMEOUT; end
      S_EXEC_R:    next_state = S_R_WB;
      S_EXEC_I:    next_state = S_I_WB;
      S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP, S_JAL, S_JR: next_state = S_FETCH;
      S_HALT:      next_state = S_HALT;
      default:     next_state = S_IDLE;
    endcase
  end

  always_comb begin
    pc_write = 1'b0; i_or_d = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    ir_write = 1'b0; reg_dest = 1'b0; mem_to_reg = 1'b0; reg_write = 1'b0;
    jal = 1'b0; alu_src_a = 1'b0; alu_src_b = 2'b00; alu_operation = 3'b010;
    pc_src = 2'b00; halted = 1'b0; halt_cause = 2'b00;
    case (state)
      S_IDLE:      alu_operation = 3'b000;
      S_FETCH: begin
        mem_read = 1'b1; alu_src_b = 2'b01;
        ir_write = mem_ready; pc_write = mem_ready;
      end
      S_DECODE:    alu_src_b = 2'b11;
      S_MEM_ADDR:  begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
      S_MEM_READ:  begin mem_read = 1'b1; i_or_d = 1'b1; end
      S_MEM_WB:    begin reg_write = 1'b1; mem_to_reg = 1'b1; end
      S_MEM_WRITE: begin mem_write = 1'b1; i_or_d = 1'b1; end
      S_EXEC_R:    begin alu_src_a = 1'b1; alu_operation = r_alu_op(funct); end
      S_R_WB:      begin reg_write = 1'b1; reg_dest = 1'b1; alu_operation = r_alu_op(funct); end
      S_EXEC_I: begin
        alu_src_a = 1'b1; alu_src_b = 2'b10;
        alu_operation = (op_q == OP_SLTI) ? 3'b111 : 3'b010;
      end
      S_I_WB: begin
        reg_write = 1'b1;
        alu_operation = (op_q == OP_SLTI) ? 3'b111 : 3'b010;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1; alu_operation = 3'b110; pc_src = 2'b01;
        pc_write = (op_q == OP_BNE) ? ~zero : zero;
      end
      S_JUMP:      begin pc_src = 2'b10; pc_write = 1'b1; end
      S_JAL:       begin pc_src = 2'b10; pc_write = 1'b1; reg_write = 1'b1; jal = 1'b1; end
      S_JR:        begin pc_src = 2'b11; pc_write = 1'b1; end
      S_HALT:      begin alu_operation = 3'b000; halted = 1'b1; halt_cause = cause_q; end
      default:     alu_operation = 3'b000;
    endcase
  end

`ifdef PERF_COUNTERS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      if (state != S_IDLE && state != S_HALT) cycle_count <= cycle_count + 1'b1;
      if (state != S_IDLE && state != S_FETCH && next_state == S_FETCH)
        instr_count <= instr_count + 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mips_multicycle_controller.sv
// ============================================================================
// Module   : tb_mips_multicycle_controller
// Purpose  : Scoreboard bench: instruction-level reference model queues the
//            expected control word of every cycle; a negedge monitor compares.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mips_multicycle_controller;
  localparam int MAX_WAIT = 15;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_ADDI = 6'b001000, OP_SLTI = 6'b001010, OP_BEQ = 6'b000100,
                         OP_BNE = 6'b000101, OP_J = 6'b000010, OP_JAL = 6'b000011;

  typedef struct packed {
    logic       pc_write, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_dest, mem_to_reg, reg_write, jal, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic       halted;
    logic [1:0] halt_cause;
  } ctl_t;

  typedef enum int {K_LW, K_SW, K_R, K_I, K_BR, K_J, K_JAL, K_JR, K_ILL} kind_t;

  logic clk = 1'b0, rst = 1'b0, zero = 1'b0, mem_ready = 1'b0;
  logic [5:0] opcode = 6'd0, funct = 6'd0;
  logic pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dest, mem_to_reg;
  logic reg_write, jal, alu_src_a, halted;
  logic [1:0] alu_src_b, pc_src, halt_cause;
  logic [2:0] alu_operation;
  ctl_t actual;

  ctl_t  exp_q[$];
  string name_q[$];
  int    tests_run = 0, tests_failed = 0;

  logic [5:0] r_functs[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  logic [2:0] r_ops[5]    = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
  logic [5:0] legal_ops[9] = '{OP_LW, OP_SW, OP_R, OP_ADDI, OP_SLTI, OP_BEQ, OP_BNE, OP_J, OP_JAL};

  mips_multicycle_controller #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dest(reg_dest),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .jal(jal), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_operation(alu_operation), .pc_src(pc_src),
    .halted(halted), .halt_cause(halt_cause)
  );

  assign actual = {pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dest, mem_to_reg,
                   reg_write, jal, alu_src_a, alu_src_b, alu_operation, pc_src, halted,
                   halt_cause};

  always #5 clk = ~clk;

  // Monitor: one expected control word per cycle, checked mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      ctl_t  e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      tests_run++;
      if (actual !== e) begin
        tests_failed++;
        $display("FAIL %s @%0t: got %h expected %h", n, $time, actual, e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // ---------------- reference model: control word per phase ----------------
  function automatic ctl_t base();
    ctl_t c = '0;
    c.alu_op = 3'b010;
    return c;
  endfunction

  function automatic ctl_t cw(input string ph, input logic [5:0] op, input logic [5:0] fn,
                              input logic z);
    ctl_t c = base();
    case (ph)
      "zero":      c = '0;
      "fetch0":    begin c.mem_read = 1; c.alu_src_b = 2'b01; end
      "fetch1":    begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = 1; c.pc_write = 1; end
      "decode":    c.alu_src_b = 2'b11;
      "mem_addr":  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      "mem_read":  begin c.mem_read = 1; c.i_or_d = 1; end
      "mem_wb":    begin c.reg_write = 1; c.mem_to_reg = 1; end
      "mem_write": begin c.mem_write = 1; c.i_or_d = 1; end
      "exec_r", "r_wb": begin
        for (int i = 0; i < 5; i++) if (r_functs[i] == fn) c.alu_op = r_ops[i];
        if (ph == "exec_r") c.alu_src_a = 1;
        else begin c.reg_write = 1; c.reg_dest = 1; end
      end
      "exec_i", "i_wb": begin
        c.alu_op = (op == OP_SLTI) ? 3'b111 : 3'b010;
        if (ph == "exec_i") begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
        else c.reg_write = 1;
      end
      "branch": begin
        c.alu_src_a = 1; c.alu_op = 3'b110; c.pc_src = 2'b01;
        c.pc_write = (op == OP_BEQ) ? z : !z;
      end
      "jump":      begin c.pc_src = 2'b10; c.pc_write = 1; end
      "jal":       begin c.pc_src = 2'b10; c.pc_write = 1; c.reg_write = 1; c.jal = 1; end
      "jr":        begin c.pc_src = 2'b11; c.pc_write = 1; end
      default:     c = '0;
    endcase
    return c;
  endfunction

  function automatic kind_t classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OP_LW:           return K_LW;
      OP_SW:           return K_SW;
      OP_ADDI, OP_SLTI: return K_I;
      OP_BEQ, OP_BNE:  return K_BR;
      OP_J:            return K_J;
      OP_JAL:          return K_JAL;
      OP_R: begin
        if (fn == 6'b001000) return K_JR;
        for (int i = 0; i < 5; i++) if (r_functs[i] == fn) return K_R;
        return K_ILL;
      end
      default:         return K_ILL;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  task automatic step(input ctl_t e, input string nm, input logic mr, input logic z);
    mem_ready = mr;
    zero      = z;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic halt_phase(input logic [1:0] cause);
    ctl_t c = '0;
    c.halted = 1;
    c.halt_cause = cause;
    repeat (3) step(c, "halt", rb(), rb());
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(cw("zero", 0, 0, 0), "reset", rb(), rb());
    step(cw("zero", 0, 0, 0), "reset", rb(), rb());
    rst = 1'b1;
    step(cw("zero", 0, 0, 0), "idle", rb(), rb());
  endtask

  // Memory phase with w not-ready cycles; times out after MAX_WAIT of them.
  task automatic mem_phase(input string ph_wait, input string ph_done, input int w,
                           output bit to);
    to = 0;
    for (int i = 0; i < w && i < MAX_WAIT; i++) step(cw(ph_wait, 0, 0, 0), ph_wait, 1'b0, rb());
    if (w >= MAX_WAIT) to = 1;
    else step(cw(ph_done, 0, 0, 0), ph_done, 1'b1, rb());
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw,
                           input int mw, input logic bz, output bit hlt);
    bit to;
    hlt    = 0;
    opcode = op;
    funct  = fn;
    mem_phase("fetch0", "fetch1", fw, to);
    if (to) begin halt_phase(2'b10); hlt = 1; return; end
    step(cw("decode", op, fn, 0), "decode", rb(), rb());
    case (classify(op, fn))
      K_LW: begin
        step(cw("mem_addr", op, fn, 0), "mem_addr", rb(), rb());
        mem_phase("mem_read", "mem_read", mw, to);
        if (to) begin halt_phase(2'b10); hlt = 1; end
        else step(cw("mem_wb", op, fn, 0), "mem_wb", rb(), rb());
      end
      K_SW: begin
        step(cw("mem_addr", op, fn, 0), "mem_addr", rb(), rb());
        mem_phase("mem_write", "mem_write", mw, to);
        if (to) begin halt_phase(2'b10); hlt = 1; end
      end
      K_R: begin
        step(cw("exec_r", op, fn, 0), "exec_r", rb(), rb());
        step(cw("r_wb", op, fn, 0), "r_wb", rb(), rb());
      end
      K_I: begin
        step(cw("exec_i", op, fn, 0), "exec_i", rb(), rb());
        step(cw("i_wb", op, fn, 0), "i_wb", rb(), rb());
      end
      K_BR:  step(cw("branch", op, fn, bz), "branch", rb(), bz);
      K_J:   step(cw("jump", op, fn, 0), "jump", rb(), rb());
      K_JAL: step(cw("jal", op, fn, 0), "jal", rb(), rb());
      K_JR:  step(cw("jr", op, fn, 0), "jr", rb(), rb());
      default: begin halt_phase(2'b01); hlt = 1; end
    endcase
  endtask

  initial begin
    bit h;
    @(posedge clk);
    #1;
    do_reset();
    // Directed scenarios
    run_instr(OP_LW, 6'd0, 0, 0, 0, h);
    run_instr(OP_R, 6'b101010, 0, 0, 0, h);
    run_instr(OP_BEQ, 6'd0, 0, 0, 1'b1, h);
    run_instr(OP_BNE, 6'd0, 0, 0, 1'b1, h);
    run_instr(OP_JAL, 6'd0, 0, 0, 0, h);
    run_instr(OP_R, 6'b001000, 0, 0, 0, h);
    run_instr(OP_LW, 6'd0, 2, MAX_WAIT - 1, 0, h);
    run_instr(OP_SW, 6'd0, MAX_WAIT - 1, 3, 0, h);
    run_instr(OP_SLTI, 6'd0, 1, 0, 0, h);
    run_instr(OP_LW, 6'd0, MAX_WAIT, 0, 0, h);       // fetch timeout
    tests_run++;
    if (halted !== 1'b1 || halt_cause !== 2'b10) begin
      tests_failed++;
      $display("FAIL timeout_halt @%0t: halted=%b cause=%b", $time, halted, halt_cause);
    end
    do_reset();
    run_instr(6'b111111, 6'd0, 0, 0, 0, h);          // illegal opcode
    tests_run++;
    if (halted !== 1'b1 || halt_cause !== 2'b01) begin
      tests_failed++;
      $display("FAIL illegal_halt @%0t: halted=%b cause=%b", $time, halted, halt_cause);
    end
    do_reset();
    run_instr(OP_R, 6'b000000, 0, 0, 0, h);          // illegal funct
    do_reset();
    run_instr(OP_LW, 6'd0, 0, MAX_WAIT, 0, h);       // memory-read timeout
    do_reset();
    // Reset asserted during a stalled store
    opcode = OP_SW;
    step(cw("fetch1", 0, 0, 0), "fetch1", 1'b1, 1'b0);
    step(cw("decode", OP_SW, 0, 0), "decode", 1'b0, 1'b0);
    step(cw("mem_addr", OP_SW, 0, 0), "mem_addr", 1'b0, 1'b0);
    repeat (3) step(cw("mem_write", 0, 0, 0), "mem_write", 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    tests_run++;
    if (mem_write !== 1'b0 || i_or_d !== 1'b0 || halted !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset @%0t: mem_write=%b i_or_d=%b halted=%b",
               $time, mem_write, i_or_d, halted);
    end
    do_reset();
    // Randomised instruction stream
    for (int n = 0; n < 200; n++) begin
      logic [5:0] op, fn;
      int fw, mw;
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 8)];
      if ($urandom_range(0, 9) == 0) fn = 6'($urandom);
      else if ($urandom_range(0, 5) == 0) fn = 6'b001000;
      else fn = r_functs[$urandom_range(0, 4)];
      fw = ($urandom_range(0, 39) == 0) ? MAX_WAIT : $urandom_range(0, 3);
      mw = ($urandom_range(0, 29) == 0) ? MAX_WAIT : $urandom_range(0, 4);
      run_instr(op, fn, fw, mw, rb(), h);
      if (h) do_reset();
    end
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    if (tests_failed == 0) $display("PASS");
    else $display("FAIL");
    $finish;
  end

endmodule

`default_nettype wire
